// File: rtl/scr84_frame_ctrl.sv
// scr84_frame_ctrl
// ----------------
// Framing stage around the 84-bit, 14-bit-per-cycle scrambler. It owns the
// scrambler state, scrambles one 14-bit word per accepted input beat, and
// can append a 6-beat residue trailer to each frame. The trailer is the final
// 84-bit state, sent most-significant slice first. Sits directly upstream of
// the serializer/TX framer.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   seed_load   load `seed` into the state (IDLE with no output pending only)
//   seed[83:0]  runtime seed value
//   in_valid    input word valid
//   in_ready    input word accepted when in_valid & in_ready
//   in_data     input word, bit i is scrambled at step i
//   in_last     final data word of the frame
//   out_valid   output word valid
//   out_ready   downstream ready
//   out_data    scrambled word or residue word
//   out_last    final beat of the frame
//   out_is_res  beat is a residue trailer word
//   busy        FSM is in DATA or RESIDUE
//   state_dbg   current FSM state (0 IDLE, 1 DATA, 2 RESIDUE)
//
// Handshake: a beat transfers on a rising edge where valid & ready are both
// high. A producer holds valid and its payload stable until that edge; ready
// may change freely and never depends on the same-side valid.
//
// Parameters
//   SEED         state loaded at reset and on auto-reseed
//   RESIDUE_EN   1 = append the 6-beat residue trailer after the last word
//   AUTO_RESEED  1 = reload SEED after each frame, 0 = state carries over
module scr84_frame_ctrl #(
    parameter logic [83:0] SEED        = 84'h1,
    parameter bit          RESIDUE_EN  = 1'b1,
    parameter bit          AUTO_RESEED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_load,
    input  logic [83:0] seed,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [13:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [13:0] out_data,
    output logic        out_last,
    output logic        out_is_res,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_RES  = 2'd2
    } fsm_t;

    fsm_t        fsm_q, fsm_d;
    logic [83:0] scr_q, scr_d;
    logic [2:0]  beat_q, beat_d;
    logic        ov_q, ov_d;
    logic [13:0] od_q, od_d;
    logic        ol_q, ol_d;
    logic        ores_q, ores_d;

    logic [83:0] step_state;
    logic [13:0] step_out;
    logic [13:0] res_word;
    logic        load_en;
    logic        seed_take;
    logic        accept;

    // Full 14-step word update, unrolled combinationally. Feedback taps sit
    // at bits 45, 51 and 59; the scrambled bit equals the new bit 0.
    always_comb begin : word_step
        logic [83:0] s;
        logic        m;
        s        = scr_q;
        m        = 1'b0;
        step_out = '0;
        for (int i = 0; i < 14; i++) begin
            m           = s[83];
            step_out[i] = m ^ in_data[i];
            s           = {s[82:0], m ^ in_data[i]};
            s[45]       = s[45] ^ m;
            s[51]       = s[51] ^ m;
            s[59]       = s[59] ^ m;
        end
        step_state = s;
    end

    // Residue beat b carries state[83-14b : 70-14b].
    always_comb begin
        res_word = '0;
        case (beat_q)
            3'd0:    res_word = scr_q[83:70];
            3'd1:    res_word = scr_q[69:56];
            3'd2:    res_word = scr_q[55:42];
            3'd3:    res_word = scr_q[41:28];
            3'd4:    res_word = scr_q[27:14];
            3'd5:    res_word = scr_q[13:0];
            default: res_word = '0;
        endcase
    end

    // Output register may reload when empty or being popped this cycle.
    assign load_en   = !ov_q || out_ready;
    // rst gates in_ready so it reads low for the whole reset pulse.
    assign in_ready  = rst && (fsm_q == S_IDLE || fsm_q == S_DATA) && load_en;
    // A honoured seed load takes priority; no word is taken in that cycle.
    assign seed_take = (fsm_q == S_IDLE) && seed_load && !ov_q;
    assign accept    = in_valid && in_ready && !seed_take;

    always_comb begin
        fsm_d  = fsm_q;
        scr_d  = scr_q;
        beat_d = beat_q;
        ov_d   = ov_q;
        od_d   = od_q;
        ol_d   = ol_q;
        ores_d = ores_q;

        // Popped with nothing new behind it: register goes empty.
        if (load_en) begin
            ov_d = 1'b0;
        end

        case (fsm_q)
            S_IDLE, S_DATA: begin
                if (seed_take) begin
                    scr_d = seed;
                end else if (accept) begin
                    scr_d  = step_state;
                    ov_d   = 1'b1;
                    od_d   = step_out;
                    ores_d = 1'b0;
                    ol_d   = in_last && !RESIDUE_EN;
                    if (!in_last) begin
                        fsm_d = S_DATA;
                    end else if (RESIDUE_EN) begin
                        fsm_d  = S_RES;
                        beat_d = 3'd0;
                    end else begin
                        fsm_d = S_IDLE;
                        if (AUTO_RESEED) begin
                            scr_d = SEED;
                        end
                    end
                end
            end
            S_RES: begin
                if (load_en) begin
                    ov_d   = 1'b1;
                    od_d   = res_word;
                    ores_d = 1'b1;
                    ol_d   = (beat_q == 3'd5);
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd5) begin
                        fsm_d  = S_IDLE;
                        beat_d = 3'd0;
                        if (AUTO_RESEED) begin
                            scr_d = SEED;
                        end
                    end
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q  <= S_IDLE;
            scr_q  <= SEED;
            beat_q <= '0;
            ov_q   <= 1'b0;
            od_q   <= '0;
            ol_q   <= 1'b0;
            ores_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            scr_q  <= scr_d;
            beat_q <= beat_d;
            ov_q   <= ov_d;
            od_q   <= od_d;
            ol_q   <= ol_d;
            ores_q <= ores_d;
        end
    end

    assign out_valid  = ov_q;
    assign out_data   = od_q;
    assign out_last   = ol_q;
    assign out_is_res = ores_q;
    assign busy       = (fsm_q != S_IDLE);
    assign state_dbg  = fsm_q;

endmodule

// File: tb/tb_scr84_frame_ctrl.sv
// tb_scr84_frame_ctrl
// -------------------
// Directed bench for scr84_frame_ctrl. Instance a uses the default
// parameters (residue trailer, auto-reseed); instance b has both disabled.
// `sel` chooses which instance the shared stimulus and checks apply to;
// the idle instance sees no traffic and always-ready output.
module tb_scr84_frame_ctrl;

    logic        clk;
    logic        rst;
    logic        seed_load;
    logic [83:0] seed;
    logic        in_valid;
    logic [13:0] in_data;
    logic        in_last;
    logic        out_ready;
    logic        sel;

    logic        a_in_ready, a_out_valid, a_out_last, a_out_is_res, a_busy;
    logic [13:0] a_out_data;
    logic [1:0]  a_state_dbg;
    logic        b_in_ready, b_out_valid, b_out_last, b_out_is_res, b_busy;
    logic [13:0] b_out_data;
    logic [1:0]  b_state_dbg;

    logic        o_in_ready, o_valid, o_last, o_res, o_busy;
    logic [13:0] o_data;
    logic [1:0]  o_state;

    int total;
    int bad;

    logic [15:0] exp_q[$];
    logic [13:0] in_w[0:7];
    logic        in_l[0:7];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    scr84_frame_ctrl dut_a (
        .clk        (clk),
        .rst        (rst),
        .seed_load  (seed_load && !sel),
        .seed       (seed),
        .in_valid   (in_valid && !sel),
        .in_ready   (a_in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (a_out_valid),
        .out_ready  (out_ready || sel),
        .out_data   (a_out_data),
        .out_last   (a_out_last),
        .out_is_res (a_out_is_res),
        .busy       (a_busy),
        .state_dbg  (a_state_dbg)
    );

    scr84_frame_ctrl #(
        .SEED        (84'h1),
        .RESIDUE_EN  (1'b0),
        .AUTO_RESEED (1'b0)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .seed_load  (seed_load && sel),
        .seed       (seed),
        .in_valid   (in_valid && sel),
        .in_ready   (b_in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (b_out_valid),
        .out_ready  (out_ready || !sel),
        .out_data   (b_out_data),
        .out_last   (b_out_last),
        .out_is_res (b_out_is_res),
        .busy       (b_busy),
        .state_dbg  (b_state_dbg)
    );

    assign o_in_ready = sel ? b_in_ready   : a_in_ready;
    assign o_valid    = sel ? b_out_valid  : a_out_valid;
    assign o_data     = sel ? b_out_data   : a_out_data;
    assign o_last     = sel ? b_out_last   : a_out_last;
    assign o_res      = sel ? b_out_is_res : a_out_is_res;
    assign o_busy     = sel ? b_busy       : a_busy;
    assign o_state    = sel ? b_state_dbg  : a_state_dbg;

    // ---------------- reference model ----------------
    // Returns {next_state, scrambled_word}.
    function automatic logic [97:0] model_word(input logic [83:0] s, input logic [13:0] d);
        logic [83:0] st;
        logic [13:0] o;
        logic        m;
        st = s;
        o  = '0;
        for (int i = 0; i < 14; i++) begin
            m    = st[83];
            o[i] = m ^ d[i];
            st   = {st[82:0], m ^ d[i]};
            if (m) st = st ^ ((84'h1 << 45) | (84'h1 << 51) | (84'h1 << 59));
        end
        return {st, o};
    endfunction

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_exp(input logic res, input logic last, input logic [13:0] d);
        exp_q.push_back({res, last, d});
    endtask

    task automatic do_seed(input logic [83:0] s);
        @(negedge clk);
        seed_load = 1'b1;
        seed      = s;
        @(negedge clk);
        seed_load = 1'b0;
    endtask

    // mode 0: out_ready always high; mode 1: toggling ready plus a 3-cycle
    // stall in the trailer. abort_at >= 0 pulses reset while the beat with
    // that scoreboard index is being presented.
    task automatic run_frame(input int n_in, input int mode, input int abort_at);
        int          idx, pops, cyc, hold, n_exp;
        logic        stalled, took;
        logic [15:0] prev, obs, e;
        idx = 0; pops = 0; cyc = 0; hold = 0; stalled = 1'b0; prev = '0;
        n_exp = exp_q.size();
        while (pops < n_exp && cyc < 400) begin
            @(negedge clk);
            if (mode == 1) begin
                if (pops == 7 && hold < 3) begin
                    out_ready = 1'b0;
                    hold++;
                end else begin
                    out_ready = cyc[0];
                end
            end else begin
                out_ready = 1'b1;
            end
            in_valid = (idx < n_in);
            in_data  = (idx < n_in) ? in_w[idx] : 14'h0;
            in_last  = (idx < n_in) ? in_l[idx] : 1'b0;
            #1;
            obs = {o_res, o_last, o_data};
            if (stalled) begin
                chk("stall_valid", {31'd0, o_valid}, 32'd1);
                chk("stall_payload", {16'd0, obs}, {16'd0, prev});
            end
            if (idx == n_in && o_busy && !sel) begin
                chk("res_in_ready_low", {31'd0, o_in_ready}, 32'd0);
                chk("res_state_dbg", {30'd0, o_state}, 32'd2);
            end
            if (sel && in_valid) begin
                chk("b2b_in_ready", {31'd0, o_in_ready}, 32'd1);
            end
            if (abort_at >= 0 && pops == abort_at && o_valid) begin
                in_valid = 1'b0;
                rst      = 1'b0;
                #1;
                chk("abort_out_valid", {31'd0, o_valid}, 32'd0);
                chk("abort_out_data", {18'd0, o_data}, 32'd0);
                chk("abort_flags", {29'd0, o_last, o_res, o_busy}, 32'd0);
                chk("abort_in_ready", {31'd0, o_in_ready}, 32'd0);
                @(negedge clk);
                rst = 1'b1;
                exp_q.delete();
                pops = n_exp;
            end else begin
                took = in_valid && o_in_ready;
                if (o_valid && out_ready) begin
                    e = exp_q.pop_front();
                    chk($sformatf("beat%0d", pops), {16'd0, obs}, {16'd0, e});
                    pops++;
                end
                stalled = o_valid && !out_ready;
                prev    = obs;
                @(posedge clk);
                if (took) idx++;
            end
            cyc++;
        end
        if (cyc >= 400) chk("frame_timeout", 32'd1, 32'd0);
        if (abort_at < 0) chk("inputs_consumed", idx, n_in);
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #1;
        if (abort_at < 0) chk("idle_after_frame", {30'd0, o_valid, o_busy}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [83:0] st;
        logic [97:0] r;
        total = 0; bad = 0;
        sel = 1'b0; rst = 1'b0; seed_load = 1'b0; seed = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("rst_out_data", {18'd0, a_out_data}, 32'd0);
        chk("rst_flags", {29'd0, a_out_last, a_out_is_res, a_busy}, 32'd0);
        chk("rst_in_ready", {31'd0, a_in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, a_in_ready}, 32'd1);

        // 1: zero seed, zero word
        do_seed(84'h0);
        in_w[0] = 14'h0000; in_l[0] = 1'b1;
        push_exp(1'b0, 1'b0, 14'h0000);
        for (int b = 0; b < 6; b++) push_exp(1'b1, b == 5, 14'h0000);
        run_frame(1, 0, -1);

        // 2: single top bit seeded
        do_seed(84'h1 << 83);
        in_w[0] = 14'h0000; in_l[0] = 1'b1;
        push_exp(1'b0, 1'b0, 14'h0001);
        push_exp(1'b1, 1'b0, 14'h0004);
        push_exp(1'b1, 1'b0, 14'h0104);
        push_exp(1'b1, 1'b0, 14'h0000);
        push_exp(1'b1, 1'b0, 14'h0000);
        push_exp(1'b1, 1'b0, 14'h0000);
        push_exp(1'b1, 1'b1, 14'h2000);
        run_frame(1, 0, -1);

        // 3: zero seed, data bit 0
        do_seed(84'h0);
        in_w[0] = 14'h0001; in_l[0] = 1'b1;
        push_exp(1'b0, 1'b0, 14'h0001);
        for (int b = 0; b < 5; b++) push_exp(1'b1, 1'b0, 14'h0000);
        push_exp(1'b1, 1'b1, 14'h2000);
        run_frame(1, 0, -1);

        // 4: backpressure on a 4-word frame
        do_seed(84'h0);
        in_w[0] = 14'h1234; in_w[1] = 14'h3FFF; in_w[2] = 14'h0A5A; in_w[3] = 14'h2001;
        for (int i = 0; i < 4; i++) in_l[i] = (i == 3);
        st = 84'h0;
        for (int i = 0; i < 4; i++) begin
            r  = model_word(st, in_w[i]);
            st = r[97:14];
            push_exp(1'b0, 1'b0, r[13:0]);
        end
        for (int b = 0; b < 6; b++) push_exp(1'b1, b == 5, st[83-14*b -: 14]);
        run_frame(4, 1, -1);

        // 5: reset while residue beat 3 is presented
        do_seed(84'h0);
        in_w[0] = 14'h0001; in_l[0] = 1'b1;
        push_exp(1'b0, 1'b0, 14'h0001);
        for (int b = 0; b < 6; b++) push_exp(1'b1, b == 5, b == 5 ? 14'h2000 : 14'h0000);
        run_frame(1, 0, 4);
        // State must be SEED (1) now: a zero word leaves bit 14 set.
        in_w[0] = 14'h0000; in_l[0] = 1'b1;
        push_exp(1'b0, 1'b0, 14'h0000);
        for (int b = 0; b < 6; b++) push_exp(1'b1, b == 5, b == 4 ? 14'h0001 : 14'h0000);
        run_frame(1, 0, -1);
        // Then scenario 3 reproduces exactly.
        do_seed(84'h0);
        in_w[0] = 14'h0001; in_l[0] = 1'b1;
        push_exp(1'b0, 1'b0, 14'h0001);
        for (int b = 0; b < 5; b++) push_exp(1'b1, 1'b0, 14'h0000);
        push_exp(1'b1, 1'b1, 14'h2000);
        run_frame(1, 0, -1);

        // 6: no trailer, no reseed, back-to-back frames carry state over
        sel = 1'b1;
        do_seed(84'h1 << 83);
        in_w[0] = 14'h0000; in_l[0] = 1'b1;
        in_w[1] = 14'h0000; in_l[1] = 1'b1;
        in_w[2] = 14'h1357; in_l[2] = 1'b0;
        in_w[3] = 14'h2AAA; in_l[3] = 1'b1;
        push_exp(1'b0, 1'b1, 14'h0001);
        push_exp(1'b0, 1'b1, 14'h0800);
        st = 84'h1 << 83;
        r  = model_word(st, 14'h0000); st = r[97:14];
        r  = model_word(st, 14'h0000); st = r[97:14];
        r  = model_word(st, in_w[2]);  st = r[97:14];
        push_exp(1'b0, 1'b0, r[13:0]);
        r  = model_word(st, in_w[3]);
        push_exp(1'b0, 1'b1, r[13:0]);
        run_frame(4, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scr84_frame_ctrl.md
Name: scr84_frame_ctrl

Overview:
Sequential framing stage that drives the 84-bit, 14-bit-per-cycle scrambler step function and owns its state register. It accepts a stream of 14-bit words with valid/ready and scrambles one word per accepted beat. Each frame ends with an optional 6-beat residue trailer: the final 84-bit state split into six 14-bit words. It sits directly upstream of the serializer/TX framer.

Parameters:
SEED, 84'h1, state value loaded at reset and on auto-reseed.
RESIDUE_EN, 1, 1 = append 6-beat residue trailer after the last data word; 0 = no trailer.
AUTO_RESEED, 1, 1 = reload SEED into the state after each frame completes; 0 = state carries over to the next frame.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  asynchronous, active-low reset.
seed_load  in  1  load seed into state; honoured only in IDLE with no output pending.
seed  in  84  runtime seed value.
in_valid  in  1  input word valid.
in_ready  out  1  input word accepted when in_valid & in_ready.
in_data  in  14  input word; bit i is processed at step i.
in_last  in  1  marks the final data word of a frame.
out_valid  out  1  output word valid.
out_ready  in  1  downstream ready.
out_data  out  14  scrambled word or residue word.
out_last  out  1  final beat of the frame.
out_is_res  out  1  beat is a residue trailer word.
busy  out  1  high in DATA or RESIDUE state.

Behaviour:
- Single-bit step on state s with input bit d:
  - m = s[83].
  - n[0] = m ^ d.
  - n[k] = s[k-1] ^ m for k in {45, 51, 59}.
  - n[k] = s[k-1] for all other k.
  - Scrambled bit = m ^ d.
- Word step: apply 14 single-bit steps for i = 0..13 using in_data[i]. out_data[i] = scrambled bit of step i. The state register takes the value after step 13. The whole word step is combinational within one cycle.
- Reset (rst = 0, async):
  - state = SEED; FSM = IDLE.
  - out_valid = 0, out_data = 0, out_last = 0, out_is_res = 0.
  - in_ready = 0 while rst is low. busy = 0.
- Output register: one stage. It may load when out_valid = 0 or out_ready = 1 (load-on-pop allowed, so throughput is 1 word/cycle). out_data/out_last/out_is_res hold stable while out_valid & !out_ready.
- in_ready = (FSM is IDLE or DATA) & (!out_valid | out_ready). in_ready is never high in RESIDUE.
- Latency: accepted word appears on out_data the next cycle.
- FSM:
  - IDLE: seed_load with !out_valid loads seed into state (in_ready is still evaluated that cycle, but no word is accepted that cycle). On accept: go to DATA, or apply end-of-frame handling if in_last.
  - DATA: each accept advances state.
  - End of frame (accept with in_last):
    - If RESIDUE_EN = 0: out_last = 1 on that word; if AUTO_RESEED = 1, state = SEED; go to IDLE.
    - If RESIDUE_EN = 1: out_last = 0; go to RESIDUE with beat counter = 0.
  - RESIDUE: each output-register load emits beat b, b = 0..5:
    - out_data = state[83-14b : 70-14b]; out_is_res = 1.
    - State does not advance.
    - On b = 5: out_last = 1; state = SEED if AUTO_RESEED; go to IDLE.
- seed_load outside IDLE, or while out_valid, is ignored (no pending effect).
- Single-word frame: in_last on the first word is legal.
- Reset mid-frame or mid-trailer: immediate abort, partial trailer discarded, reset values as above.

Test Plan:
1. Reset, seed_load seed = 0, send one word 14'h0000 with in_last -> out 14'h0000; residue beats 0,0,0,0,0,0 with out_last on beat 5.
2. seed = 84'h1 << 83, word 14'h0000 with in_last -> out 14'h0001; final state has bits {13, 58, 64, 72} set; residue 14'h0004, 14'h0104, 0, 0, 0, 14'h2000.
3. seed = 0, word 14'h0001 with in_last -> out 14'h0001; residue 0, 0, 0, 0, 0, 14'h2000.
4. Backpressure: 4-word frame, out_ready toggled 1010... and held low 3 cycles mid-trailer -> no beat lost or duplicated, out_data stable while stalled, in_ready low through RESIDUE.
5. Reset asserted during residue beat 3 -> out_valid = 0 immediately, state = SEED. Next frame with seed 0, word 14'h0001 reproduces scenario 3 exactly.
6. AUTO_RESEED = 0, RESIDUE_EN = 0: two back-to-back frames -> second frame continues from the first frame's final state (compare against the model), out_last on each in_last word, zero idle cycles between frames.
